// File: rtl/matmul_seq_ctrl_if.sv
// Handshake and RAM bus bundle for the matrix-multiply sequencer.
// master = sequencer, slave = surrounding datapath / job control.
interface matmul_seq_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int COL_W  = 3,
    parameter int MUL_W  = 4
);
    logic              start_in;
    logic              abort;
    logic              reload_each_col;
    logic              xload_done;
    logic              aload_done;
    logic              alu_done;
    logic              ram_ready;
    logic              input_load_en;
    logic              rom_start;
    logic              alu_en;
    logic              alu_clr;
    logic              ram_en;
    logic              web;
    logic [ADDR_W-1:0] ram_addr;
    logic [COL_W-1:0]  col_idx;
    logic [MUL_W-1:0]  mul_idx;
    logic              busy;
    logic              finish;

    modport master (
        input  start_in, abort, reload_each_col,
        input  xload_done, aload_done, alu_done, ram_ready,
        output input_load_en, rom_start, alu_en, alu_clr,
        output ram_en, web, ram_addr, col_idx, mul_idx,
        output busy, finish
    );

    modport slave (
        output start_in, abort, reload_each_col,
        output xload_done, aload_done, alu_done, ram_ready,
        input  input_load_en, rom_start, alu_en, alu_clr,
        input  ram_en, web, ram_addr, col_idx, mul_idx,
        input  busy, finish
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Column sequencer for the matmul datapath: load, MAC issue,
// ALU wait and RAM write-back over N_COLS columns.
module matmul_seq_ctrl #(
    parameter int MUL_STEPS = 8,
    parameter int N_COLS    = 4,
    parameter int ROWS      = 4,
    parameter int ADDR_W    = 5,
    parameter int RAM_BASE  = 0
) (
    input logic               clk,
    input logic               rst,
    matmul_seq_ctrl_if.master bus
);
    localparam int COL_W = $clog2(N_COLS) + 1;
    localparam int MUL_W = $clog2(MUL_STEPS) + 1;
    localparam int ROW_W = $clog2(ROWS) + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
    localparam logic [MUL_W-1:0] MUL_LAST = MUL_W'(MUL_STEPS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [COL_W-1:0] col;
    logic [MUL_W-1:0] mul;
    logic [ROW_W-1:0] row;
    logic             xf;
    logic             af;
    logic             rl;
    logic             first;
    logic             loads_ok;

    assign loads_ok = (xf | bus.xload_done) & (af | bus.aload_done);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    // Counters, sticky load flags and latched job options
    always_ff @(posedge clk) begin
        if (!rst) begin
            col   <= '0;
            mul   <= '0;
            row   <= '0;
            xf    <= 1'b0;
            af    <= 1'b0;
            rl    <= 1'b0;
            first <= 1'b0;
        end else begin
            if (state == S_MAC && nxt == S_MAC) mul <= mul + MUL_W'(1);
            else                                mul <= '0;

            if (state == S_WRITE && nxt == S_WRITE)
                row <= bus.ram_ready ? row + ROW_W'(1) : row;
            else
                row <= '0;

            if (nxt == S_IDLE)
                col <= '0;
            else if (state == S_NEXT && nxt != S_DONE)
                col <= col + COL_W'(1);

            if (state == S_LOAD && nxt == S_LOAD) begin
                xf <= xf | bus.xload_done;
                af <= af | bus.aload_done;
            end else begin
                xf <= 1'b0;
                af <= 1'b0;
            end

            if (state == S_IDLE && bus.start_in)
                rl <= bus.reload_each_col;

            first <= (nxt == S_LOAD) && (state != S_LOAD);
        end
    end

    // Next state and Moore output decode
    always_comb begin
        nxt               = state;
        bus.input_load_en = 1'b0;
        bus.rom_start     = 1'b0;
        bus.alu_en        = 1'b0;
        bus.alu_clr       = 1'b0;
        bus.ram_en        = 1'b0;
        bus.web           = 1'b1;
        bus.ram_addr      = '0;
        bus.col_idx       = col;
        bus.mul_idx       = mul;
        bus.busy          = (state != S_IDLE);
        bus.finish        = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.start_in) nxt = S_LOAD;
            end
            S_LOAD: begin
                bus.input_load_en = 1'b1;
                bus.rom_start     = first;
                if (loads_ok) nxt = S_MAC;
            end
            S_MAC: begin
                bus.alu_en  = 1'b1;
                bus.alu_clr = (mul == '0);
                if (mul == MUL_LAST) nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.alu_done) nxt = S_WRITE;
            end
            S_WRITE: begin
                bus.ram_en   = 1'b1;
                bus.web      = 1'b0;
                bus.ram_addr = ADDR_W'(RAM_BASE)
                             + ADDR_W'(col) * ADDR_W'(ROWS)
                             + ADDR_W'(row);
                if (bus.ram_ready && row == ROW_LAST) nxt = S_NEXT;
            end
            S_NEXT: begin
                if (col == COL_LAST) nxt = S_DONE;
                else if (rl)         nxt = S_LOAD;
                else                 nxt = S_MAC;
            end
            S_DONE: begin
                bus.finish = 1'b1;
                nxt        = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase

        if (bus.abort && state != S_IDLE) nxt = S_IDLE;
    end
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: directed and randomized jobs checked
// against an arithmetic job-timing and write-order model.
module tb_matmul_seq_ctrl;
    localparam int M0 = 8;
    localparam int C0 = 4;
    localparam int R0 = 4;
    localparam int B0 = 0;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    int dx [C0];
    int da [C0];
    int dw [C0];
    int st [C0][R0];
    bit lvl;

    matmul_seq_ctrl_if #(.ADDR_W(5), .COL_W(3), .MUL_W(4)) b0 ();
    matmul_seq_ctrl_if #(.ADDR_W(5), .COL_W(1), .MUL_W(1)) b1 ();

    matmul_seq_ctrl dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    matmul_seq_ctrl #(
        .MUL_STEPS (1),
        .N_COLS    (1),
        .ROWS      (1),
        .ADDR_W    (5),
        .RAM_BASE  (7)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_zero();
        for (int c = 0; c < C0; c++) begin
            dx[c] = 0;
            da[c] = 0;
            dw[c] = 0;
            for (int r = 0; r < R0; r++) st[c][r] = 0;
        end
    endtask

    task automatic set_rand();
        for (int c = 0; c < C0; c++) begin
            dx[c] = $urandom_range(0, 3);
            da[c] = $urandom_range(0, 3);
            dw[c] = $urandom_range(0, 3);
            for (int r = 0; r < R0; r++) st[c][r] = $urandom_range(0, 2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 full job, 1 abort on first write of column 1,
    //       2 reset on third MAC cycle of column 0
    task automatic run_job(input bit rl, input int kind);
        int exp_fin, exp_ld, exp_first, lmax;
        int fin_cyc, fins, roms, alus, clrs, lds, first_alu, nwr;
        int li, wi, sc, col, row, cyc;
        int pf, pw;
        bit prev_ld, prev_alu, waiting, done, hit;

        exp_fin = 1;
        exp_ld  = 0;
        for (int c = 0; c < C0; c++) begin
            lmax = ((dx[c] > da[c]) ? dx[c] : da[c]) + 1;
            if (c == 0 || rl) begin
                exp_fin += lmax;
                exp_ld  += lmax;
            end
            exp_fin += M0 + dw[c] + 1 + R0 + 1;
            for (int r = 0; r < R0; r++) exp_fin += st[c][r];
        end
        exp_first = 1 + ((dx[0] > da[0]) ? dx[0] : da[0]) + 1;

        fin_cyc = -1; fins = 0; roms = 0; alus = 0; clrs = 0;
        lds = 0; first_alu = -1; nwr = 0; li = 0; wi = 0; sc = 0;
        prev_ld = 0; prev_alu = 0; waiting = 0; done = 0; hit = 0;

        b0.reload_each_col = rl;
        b0.start_in = 1'b1;
        tick();
        b0.reload_each_col = 1'($urandom_range(0, 1));

        for (cyc = 1; cyc <= exp_fin + 40 && !done; cyc++) begin
            col = nwr / R0;
            row = nwr % R0;
            if (b0.finish) begin
                fins++;
                fin_cyc = cyc;
                done = 1;
            end
            if (b0.rom_start) roms++;
            if (b0.alu_en) begin
                alus++;
                if (first_alu < 0) first_alu = cyc;
                chk("mul_idx", b0.mul_idx, (alus - 1) % M0);
            end
            if (b0.alu_clr) clrs++;
            if (b0.input_load_en) lds++;
            b0.start_in = done ? 1'b0 : 1'($urandom_range(0, 1));

            if (b0.input_load_en) begin
                li = prev_ld ? li + 1 : 0;
                b0.xload_done = lvl ? (li >= dx[col]) : (li == dx[col]);
                b0.aload_done = lvl ? (li >= da[col]) : (li == da[col]);
            end else begin
                b0.xload_done = 1'b0;
                b0.aload_done = 1'b0;
            end

            if (b0.alu_en) begin
                b0.alu_done = 1'($urandom_range(0, 1));
                waiting = 0;
            end else begin
                if (prev_alu) begin
                    waiting = 1;
                    wi = 0;
                end else if (waiting) begin
                    wi++;
                end
                b0.alu_done = waiting && (wi == dw[col]);
                if (b0.alu_done) waiting = 0;
            end

            b0.abort = 1'b0;
            if (b0.ram_en) begin
                chk("ram_addr", b0.ram_addr, B0 + col * R0 + row);
                chk("web_wr", b0.web, 0);
                chk("col_idx", b0.col_idx, col);
                if (kind == 1 && nwr == R0) begin
                    b0.abort = 1'b1;
                    b0.ram_ready = 1'b0;
                    hit = 1;
                end else begin
                    b0.ram_ready = (sc == st[col][row]);
                    if (b0.ram_ready) begin
                        nwr++;
                        sc = 0;
                    end else begin
                        sc++;
                    end
                end
            end else begin
                b0.ram_ready = 1'($urandom_range(0, 1));
            end

            if (kind == 2 && b0.alu_en && alus == 3) begin
                rst = 1'b0;
                hit = 1;
            end

            if (hit) begin
                b0.start_in = 1'b0;
                b0.xload_done = 1'b0;
                b0.aload_done = 1'b0;
                tick();
                rst = 1'b1;
                b0.abort = 1'b0;
                chk("ab_busy", b0.busy, 0);
                chk("ab_web", b0.web, 1);
                chk("ab_ram_en", b0.ram_en, 0);
                chk("ab_alu_en", b0.alu_en, 0);
                chk("ab_col", b0.col_idx, 0);
                pf = 0;
                pw = 0;
                for (int k = 0; k < 12; k++) begin
                    if (b0.finish) pf++;
                    if (b0.ram_en) pw++;
                    tick();
                end
                chk("ab_finish", pf, 0);
                chk("ab_writes", pw, 0);
                return;
            end

            prev_ld = b0.input_load_en;
            prev_alu = b0.alu_en;
            if (!done) tick();
        end

        b0.xload_done = 1'b0;
        b0.aload_done = 1'b0;
        b0.alu_done = 1'b0;
        b0.ram_ready = 1'b0;
        chk("fin_cycle", fin_cyc, exp_fin);
        chk("fin_count", fins, 1);
        chk("writes", nwr, C0 * R0);
        chk("rom_start", roms, rl ? C0 : 1);
        chk("alu_en", alus, C0 * M0);
        chk("alu_clr", clrs, C0);
        chk("load_cyc", lds, exp_ld);
        chk("first_alu", first_alu, exp_first);
        tick();
        chk("idle_busy", b0.busy, 0);
    endtask

    initial begin
        int a1, c1, w1, f1, f1c;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        lvl = 0;
        b0.start_in = 0; b0.abort = 0; b0.reload_each_col = 0;
        b0.xload_done = 0; b0.aload_done = 0;
        b0.alu_done = 0; b0.ram_ready = 0;
        b1.start_in = 0; b1.abort = 0; b1.reload_each_col = 0;
        b1.xload_done = 0; b1.aload_done = 0;
        b1.alu_done = 0; b1.ram_ready = 0;
        repeat (3) tick();

        chk("rst_ctl0", {b0.busy, b0.finish, b0.input_load_en,
                         b0.rom_start, b0.alu_en, b0.alu_clr,
                         b0.ram_en, b0.web}, 8'b0000_0001);
        chk("rst_addr0", b0.ram_addr, 0);
        chk("rst_col0", b0.col_idx, 0);
        chk("rst_mul0", b0.mul_idx, 0);
        chk("rst_ctl1", {b1.busy, b1.finish, b1.input_load_en,
                         b1.rom_start, b1.alu_en, b1.alu_clr,
                         b1.ram_en, b1.web}, 8'b0000_0001);
        chk("rst_addr1", b1.ram_addr, 0);
        rst = 1'b1;
        tick();

        set_zero();
        run_job(0, 0);

        set_zero();
        dx[0] = 2;
        da[0] = 6;
        run_job(0, 0);

        set_zero();
        run_job(1, 0);

        set_zero();
        st[0][2] = 3;
        run_job(0, 0);

        set_zero();
        run_job(0, 1);
        run_job(0, 0);
        run_job(1, 2);
        run_job(0, 0);

        repeat (6) begin
            set_rand();
            lvl = 1'($urandom_range(0, 1));
            run_job(1'($urandom_range(0, 1)), 0);
        end

        a1 = 0; c1 = 0; w1 = 0; f1 = 0; f1c = -1;
        b1.xload_done = 1;
        b1.aload_done = 1;
        b1.alu_done = 1;
        b1.ram_ready = 1;
        b1.start_in = 1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            if (b1.alu_en) begin
                a1++;
                if (b1.alu_clr) c1++;
            end
            if (b1.ram_en && !b1.web) begin
                w1++;
                chk("d1_addr", b1.ram_addr, 7);
            end
            if (b1.finish) begin
                f1++;
                f1c = k;
            end
            b1.start_in = (k <= 4);
            tick();
        end
        chk("d1_alu_en", a1, 1);
        chk("d1_alu_clr", c1, 1);
        chk("d1_writes", w1, 1);
        chk("d1_fin_cnt", f1, 1);
        chk("d1_fin_cyc", f1c, 1 + 1 + 1 + 1 + 1 + 1);
        chk("d1_idle", b1.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
